imem_boot_loader: RTL

//   Boot-time controller for the byte-addressable instruction memory.

---
 rtl/imem_boot_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
//------------------------------------------------------------------------------
// Module   : imem_boot_loader
// Purpose  : Boot-time loader for a byte-addressable instruction memory.
//            Accepts a program image as a valid/ready byte stream, writes it
//            little-endian from address 0 through the memory write port, and
//            holds the core in reset until a complete image has been loaded.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            load_start/len/abort       - load control
//            rx_data/valid/ready        - byte stream handshake
//            mem_we/addr/wdata          - instruction memory byte write port
//            core_reset, busy, done,
//            error, checksum            - status (all registered)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_boot_loader #(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        checksum
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [ADDR_W:0] C_MEM_BYTES = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] C_ONE       = (ADDR_W+1)'(1);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic              r_rx_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_core_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [7:0]        r_checksum;

  logic w_in_load;
  logic w_xfer;
  logic w_last;
  logic w_len_bad;

  assign w_in_load = (r_state == S_LOAD);
  // Abort wins over a byte offered in the same cycle: that byte is not taken.
  assign w_xfer    = w_in_load && rx_valid && r_rx_ready && !load_abort;
  assign w_last    = (r_cnt == (r_len - C_ONE));
  // Image must be a non-zero whole number of 32-bit words that fits in memory.
  assign w_len_bad = (load_len == '0) || (load_len[1:0] != 2'b00) ||
                     (load_len > C_MEM_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_rx_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_checksum   <= '0;
    end else begin
      // Write strobe is a one-cycle pulse following each accepted byte.
      r_mem_we <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (load_abort) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_xfer) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_cnt[ADDR_W-1:0];
            r_mem_wdata <= rx_data;
            r_cnt       <= r_cnt + C_ONE;
            r_checksum  <= r_checksum ^ rx_data;
            if (w_last) begin
              // Core is released in the same cycle the last byte is written.
              r_state      <= S_DONE;
              r_rx_ready   <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERR all (re)evaluate a new load request.
          if (load_start) begin
            r_core_reset <= 1'b1;
            r_done       <= 1'b0;
            if (w_len_bad) begin
              r_state    <= S_ERR;
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
              r_rx_ready <= 1'b0;
            end else begin
              r_state    <= S_LOAD;
              r_error    <= 1'b0;
              r_busy     <= 1'b1;
              r_rx_ready <= 1'b1;
              r_len      <= load_len;
              r_cnt      <= '0;
              r_checksum <= '0;
            end
          end
        end
      endcase
    end
  end

  assign rx_ready   = r_rx_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_reset = r_core_reset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign checksum   = r_checksum;

endmodule

`default_nettype wire
